hack_mem_arbiter: RTL and testbench
===================================

# hack_mem_arbiter

Arbiter that shares the single-port Hack data RAM between the CPU data port and a debug/loader port. The loader fills or inspects RAM, e.g. reloading a test image, while the CPU keeps running. The arbiter serializes accesses, registers every RAM command, returns read data with a one-cycle ready pulse and keeps a saturating count of CPU wait cycles. It sits between the CPU memory interface and the 32K x 16 RAM inside the computer top level.

## Interface
- ADDR_W, 15, RAM word-address width
- DATA_W, 16, RAM word width
- DBG_PRIORITY, 0, 0 = round-robin on ties; 1 = debug port always wins ties
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same rules as CPU
- dbg_ready  out  1  one-cycle completion pulse to debug port
- dbg_rdata  out  DATA_W  read data, valid while dbg_ready=1
- ram_en  out  1  RAM access strobe (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en
- cpu_wait_cycles  out  16  saturating count of cycles with cpu_req=1 and cpu_ready=0

## Operation
- States are IDLE, ISSUE and DONE.
- IDLE: if no request, stay. Otherwise pick a winner, latch its we/addr/wdata and the grant id, and go to ISSUE.
- Winner selection:
  - Only one request: that requester wins.
  - Both request and DBG_PRIORITY=1: debug wins.
  - Both request and DBG_PRIORITY=0: the port not granted last wins. last_grant resets to DBG, so the CPU wins the first tie.
- ISSUE: ram_en=1 and ram_we/addr/wdata come from the latches; next state is DONE.
- DONE: ram_en=0. Assert ready only for the granted port. Its rdata is ram_rdata for reads and 0 for writes. The other port's ready=0 and rdata=0. Update last_grant; next state is IDLE.
- The granted requester's req is ignored in DONE. A requester drops req in the cycle after ready.
- Request fields are sampled only in IDLE. Changes to req or fields after grant do not affect the access in flight, and ready still pulses even if req was dropped.
- cpu_wait_cycles increments in every cycle where cpu_req=1 and cpu_ready=0, and holds at 16'hFFFF once saturated.
- Writes and reads share identical sequencing.

## Timing
- Reset values: state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, both ready=0, both rdata=0, last_grant=DBG, cpu_wait_cycles=0.
- Latency: req seen in IDLE at cycle t -> ram_en=1 in cycle t+1 -> ready=1 in cycle t+2 -> IDLE in cycle t+3. Each access takes 3 cycles.
- An uncontended requester holding req continuously gets ready every 3 cycles.
- A losing requester waits at most one full access (3 cycles) beyond its own 3-cycle latency in round-robin mode. In DBG_PRIORITY=1 the CPU can starve under continuous debug traffic; this is intended for reload.
- Reset asserted mid-access:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - If reset lands in ISSUE, the write is aborted: ram_en drops asynchronously. Whether RAM captured it at an already-passed edge is outside the arbiter.
  - No ready is produced for the aborted access.
- Reset release: first arbitration happens on the first rising edge with reset=0.
- ready is never asserted to both ports in the same cycle. ram_en is never high for two consecutive cycles.

## Test plan
- **Reset:** assert reset mid-ISSUE of a CPU write to addr 5 -> ram_en, cpu_ready and cpu_wait_cycles drop to 0 asynchronously; state returns to IDLE.
- **Single CPU write then read:** write 16'h1234 to addr 7, then read addr 7. Check:
  - ram_en at t+1 with ram_we=1 for the write.
  - cpu_ready at t+2.
  - The read returns cpu_rdata=16'h1234 on its ready cycle.
- **Simultaneous requests, DBG_PRIORITY=0:** both held high from reset. Check:
  - Grants alternate CPU, DBG, CPU, ...
  - ready pulses on cycles 2, 5, 8, ... with alternating owner.
- **Simultaneous requests, DBG_PRIORITY=1:** check:
  - Debug is granted every time while dbg_req stays high.
  - cpu_wait_cycles climbs by 1 per cycle.
  - The CPU is granted only after dbg_req drops.
- **Request change after grant:** CPU latches addr 3, then changes cpu_addr to 9 and drops cpu_req during ISSUE. Check that ram_addr=3 and that cpu_ready still pulses once.
- **Saturation:** hold cpu_req with debug priority for 70000 cycles -> cpu_wait_cycles stops at 16'hFFFF.

Source files
------------

// File: rtl/hack_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  hack_mem_arbiter_if
//  CPU, debug and RAM-side signals of the Hack data-RAM arbiter.
//  Revision: 1.0
// ============================================================================
interface hack_mem_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ready;
   logic [DATA_W-1:0] dbg_rdata;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   // Requester / RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface
`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  hack_mem_arbiter
//  Serializes CPU and debug accesses to the single-port Hack data RAM.
//  Revision: 1.0
// ============================================================================
module hack_mem_arbiter #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 16,
   parameter bit DBG_PRIORITY = 1'b0
) (
   input  wire               clk,
   input  wire               reset,
   hack_mem_arbiter_if.slave bus,
   output logic [15:0]       cpu_wait_cycles
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [15:0]       wait_q, wait_d;
   logic              pick_dbg;

   // Debug wins when alone, when it has priority, or when the CPU had the last turn.
   assign pick_dbg = bus.dbg_req &&
                     (!bus.cpu_req || DBG_PRIORITY || (last_grant_q == GNT_CPU));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         grant_q      <= GNT_CPU;
         last_grant_q <= GNT_DBG;
         wait_q       <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wait_q       <= wait_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req || bus.dbg_req) begin
               state_d = S_ISSUE;
               if (pick_dbg) begin
                  grant_d = GNT_DBG;
                  we_d    = bus.dbg_we;
                  addr_d  = bus.dbg_addr;
                  wdata_d = bus.dbg_wdata;
               end else begin
                  grant_d = GNT_CPU;
                  we_d    = bus.cpu_we;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
               end
            end
         end
         S_ISSUE: state_d = S_DONE;
         S_DONE: begin
            state_d      = S_IDLE;
            last_grant_d = grant_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
      bus.cpu_ready = 1'b0;
      bus.cpu_rdata = '0;
      bus.dbg_ready = 1'b0;
      bus.dbg_rdata = '0;
      case (state_q)
         S_ISSUE: begin
            bus.ram_en = 1'b1;
            bus.ram_we = we_q;
         end
         S_DONE: begin
            if (grant_q == GNT_CPU) begin
               bus.cpu_ready = 1'b1;
               bus.cpu_rdata = we_q ? '0 : bus.ram_rdata;
            end else begin
               bus.dbg_ready = 1'b1;
               bus.dbg_rdata = we_q ? '0 : bus.ram_rdata;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if (bus.cpu_req && !bus.cpu_ready && (wait_q != 16'hFFFF))
         wait_d = wait_q + 16'd1;
   end

   assign cpu_wait_cycles = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_hack_mem_arbiter
//  Directed checks of hack_mem_arbiter in round-robin and debug-priority builds.
//  Revision: 1.0
// ============================================================================
module tb_hack_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset0;
   logic        reset1;
   logic [15:0] wait0;
   logic [15:0] wait1;
   int          n_chk = 0;
   int          n_err = 0;

   hack_mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus0 ();
   hack_mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus1 ();

   hack_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .DBG_PRIORITY(1'b0)) u_rr (
      .clk(clk), .reset(reset0), .bus(bus0), .cpu_wait_cycles(wait0));
   hack_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .DBG_PRIORITY(1'b1)) u_pri (
      .clk(clk), .reset(reset1), .bus(bus1), .cpu_wait_cycles(wait1));

   always #5 clk = ~clk;

   // RAM models: read data valid the cycle after ram_en
   logic [15:0] mem0 [0:32767];
   logic [15:0] mem1 [0:32767];
   always @(posedge clk) begin
      if (bus0.ram_en) begin
         if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_wdata;
         else             bus0.ram_rdata      <= mem0[bus0.ram_addr];
      end
   end
   always @(posedge clk) begin
      if (bus1.ram_en) begin
         if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
         else             bus1.ram_rdata      <= mem1[bus1.ram_addr];
      end
   end

   typedef struct {
      bit          dbg;
      bit          we;
      logic [14:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One uncontended access on the round-robin instance, starting in IDLE.
   task automatic do_access(input vec_t v);
      @(negedge clk);
      if (v.dbg) begin
         bus0.dbg_req = 1'b1; bus0.dbg_we = v.we; bus0.dbg_addr = v.addr; bus0.dbg_wdata = v.wdata;
      end else begin
         bus0.cpu_req = 1'b1; bus0.cpu_we = v.we; bus0.cpu_addr = v.addr; bus0.cpu_wdata = v.wdata;
      end
      @(negedge clk);
      chk("issue_ram_en", {31'd0, bus0.ram_en}, 32'd1);
      chk("issue_ram_we", {31'd0, bus0.ram_we}, {31'd0, v.we});
      chk("issue_ram_addr", {17'd0, bus0.ram_addr}, {17'd0, v.addr});
      if (v.we) chk("issue_ram_wdata", {16'd0, bus0.ram_wdata}, {16'd0, v.wdata});
      chk("issue_no_ready", {30'd0, bus0.cpu_ready, bus0.dbg_ready}, 32'd0);
      @(negedge clk);
      chk("done_ram_en", {31'd0, bus0.ram_en}, 32'd0);
      if (v.dbg) begin
         chk("done_ready", {30'd0, bus0.cpu_ready, bus0.dbg_ready}, 32'd1);
         chk("done_dbg_rdata", {16'd0, bus0.dbg_rdata}, {16'd0, v.exp_rdata});
         chk("done_cpu_rdata", {16'd0, bus0.cpu_rdata}, 32'd0);
         bus0.dbg_req = 1'b0;
      end else begin
         chk("done_ready", {30'd0, bus0.cpu_ready, bus0.dbg_ready}, 32'd2);
         chk("done_cpu_rdata", {16'd0, bus0.cpu_rdata}, {16'd0, v.exp_rdata});
         chk("done_dbg_rdata", {16'd0, bus0.dbg_rdata}, 32'd0);
         bus0.cpu_req = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 15'd7,      16'h1234, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 15'd7,      16'h0000, 16'h1234};
      vecs[2] = '{1'b1, 1'b1, 15'd100,    16'hABCD, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 15'd100,    16'h0000, 16'hABCD};
      vecs[4] = '{1'b0, 1'b0, 15'd100,    16'h0000, 16'hABCD};
      vecs[5] = '{1'b1, 1'b0, 15'd7,      16'h0000, 16'h1234};
      vecs[6] = '{1'b0, 1'b1, 15'd3,      16'h0333, 16'h0000};
      vecs[7] = '{1'b1, 1'b1, 15'd5,      16'h0F0F, 16'h0000};
      vecs[8] = '{1'b0, 1'b1, 15'h7FFF,   16'hFFFF, 16'h0000};
      vecs[9] = '{1'b1, 1'b0, 15'h7FFF,   16'h0000, 16'hFFFF};

      reset0 = 1'b1; reset1 = 1'b1;
      bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
      bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
      bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
      bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = 0; bus1.dbg_wdata = 0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ram_en", {30'd0, bus0.ram_en, bus1.ram_en}, 32'd0);
      chk("rst_ram_we", {30'd0, bus0.ram_we, bus1.ram_we}, 32'd0);
      chk("rst_ram_addr", {2'd0, bus0.ram_addr, bus1.ram_addr}, 32'd0);
      chk("rst_ram_wdata", {bus0.ram_wdata, bus1.ram_wdata}, 32'd0);
      chk("rst_ready", {28'd0, bus0.cpu_ready, bus0.dbg_ready, bus1.cpu_ready, bus1.dbg_ready}, 32'd0);
      chk("rst_rdata0", {bus0.cpu_rdata, bus0.dbg_rdata}, 32'd0);
      chk("rst_wait", {wait0, wait1}, 32'd0);
      reset0 = 1'b0;

      // Single-port accesses; CPU accrues 2 wait cycles per access
      for (int i = 0; i < 10; i++) do_access(vecs[i]);
      chk("wait_after_table", {16'd0, wait0}, 32'd10);

      // Request change after grant
      @(negedge clk);
      bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 15'd3;
      @(negedge clk);
      chk("chg_ram_en", {31'd0, bus0.ram_en}, 32'd1);
      chk("chg_ram_addr", {17'd0, bus0.ram_addr}, 32'd3);
      bus0.cpu_addr = 15'd9; bus0.cpu_req = 1'b0;
      @(negedge clk);
      chk("chg_ready", {31'd0, bus0.cpu_ready}, 32'd1);
      chk("chg_rdata", {16'd0, bus0.cpu_rdata}, 32'h0333);
      @(negedge clk);
      chk("chg_ready_once", {31'd0, bus0.cpu_ready}, 32'd0);
      @(negedge clk);
      chk("chg_no_reissue", {31'd0, bus0.ram_en}, 32'd0);
      chk("chg_wait", {16'd0, wait0}, 32'd11);

      // Reset asserted mid-ISSUE of a CPU write to addr 5
      bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 15'd5; bus0.cpu_wdata = 16'h5555;
      @(negedge clk);
      chk("arst_issue", {30'd0, bus0.ram_en, bus0.ram_we}, 32'd3);
      #2 reset0 = 1'b1;
      #1;
      chk("arst_ram_en", {31'd0, bus0.ram_en}, 32'd0);
      chk("arst_ram_addr", {17'd0, bus0.ram_addr}, 32'd0);
      chk("arst_ram_wdata", {16'd0, bus0.ram_wdata}, 32'd0);
      chk("arst_ready", {31'd0, bus0.cpu_ready}, 32'd0);
      chk("arst_wait", {16'd0, wait0}, 32'd0);
      bus0.cpu_req = 1'b0;
      @(negedge clk);
      chk("arst_no_ready", {30'd0, bus0.cpu_ready, bus0.dbg_ready}, 32'd0);
      reset0 = 1'b0;
      do_access('{1'b0, 1'b0, 15'd5, 16'h0000, 16'h0F0F});

      // Round-robin tie from reset
      @(negedge clk);
      reset0 = 1'b1;
      bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 15'd7;
      bus0.dbg_req = 1'b1; bus0.dbg_we = 1'b0; bus0.dbg_addr = 15'd100;
      @(negedge clk);
      reset0 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         bit rdy, own_cpu;
         @(negedge clk);
         rdy     = (c % 3) == 2;
         own_cpu = (((c - 1) / 3) % 2) == 0;
         chk("rr_cpu_ready", {31'd0, bus0.cpu_ready}, {31'd0, rdy && own_cpu});
         chk("rr_dbg_ready", {31'd0, bus0.dbg_ready}, {31'd0, rdy && !own_cpu});
         if ((c % 3) == 1)
            chk("rr_issue_addr", {17'd0, bus0.ram_addr}, own_cpu ? 32'd7 : 32'd100);
         if (rdy && own_cpu)  chk("rr_cpu_rdata", {16'd0, bus0.cpu_rdata}, 32'h1234);
         if (rdy && !own_cpu) chk("rr_dbg_rdata", {16'd0, bus0.dbg_rdata}, 32'hABCD);
      end
      bus0.cpu_req = 1'b0; bus0.dbg_req = 1'b0;

      // Debug priority: CPU waits until dbg_req drops
      reset1 = 1'b1;
      bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b1; bus1.cpu_addr = 15'd20; bus1.cpu_wdata = 16'h0001;
      bus1.dbg_req = 1'b1; bus1.dbg_we = 1'b1; bus1.dbg_addr = 15'd30; bus1.dbg_wdata = 16'h0002;
      @(negedge clk);
      reset1 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("pri_wait", {16'd0, wait1}, c);
         chk("pri_cpu_ready", {31'd0, bus1.cpu_ready}, 32'd0);
         chk("pri_dbg_ready", {31'd0, bus1.dbg_ready}, {31'd0, (c % 3) == 2});
      end
      bus1.dbg_req = 1'b0;
      @(negedge clk);
      chk("pri_idle_ready", {30'd0, bus1.cpu_ready, bus1.dbg_ready}, 32'd0);
      @(negedge clk);
      chk("pri_cpu_issue", {31'd0, bus1.ram_en}, 32'd1);
      chk("pri_cpu_addr", {17'd0, bus1.ram_addr}, 32'd20);
      @(negedge clk);
      chk("pri_cpu_ready_late", {30'd0, bus1.cpu_ready, bus1.dbg_ready}, 32'd2);
      chk("pri_wait_final", {16'd0, wait1}, 32'd11);
      bus1.cpu_req = 1'b0;
      @(negedge clk);
      chk("pri_wait_hold", {16'd0, wait1}, 32'd11);

      // Saturation under continuous debug traffic
      bus1.cpu_req = 1'b1; bus1.dbg_req = 1'b1;
      repeat (70000) @(negedge clk);
      chk("sat_wait", {16'd0, wait1}, 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
